// File: rtl/nios2_small_mem_pkg.sv
// nios2_small_mem_pkg: shared defaults, port indices and lock FSM states for the on-chip memory arbiter
package nios2_small_mem_pkg;
    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 10240;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    typedef enum logic [1:0] {ST_OPEN, ST_LOCK0, ST_LOCK1} lock_state_e;
endpackage

// File: rtl/nios2_small_rr_arb2.sv
// nios2_small_rr_arb2: two-way round-robin grant with a lock that pins the grant to one owner
module nios2_small_rr_arb2
    import nios2_small_mem_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    output logic [1:0] gnt_o
);
    lock_state_e state_q, state_d;
    logic        rr_last_q, rr_last_d;

    always_comb begin
        gnt_o = reset ? 2'b00 :
                (state_q == ST_LOCK0) ? {1'b0, req_i[0]} :
                (state_q == ST_LOCK1) ? {req_i[1], 1'b0} :
                (&req_i) ? ((rr_last_q == PORT1) ? 2'b01 : 2'b10) : req_i;
    end

    // A lock ends when the owner releases it on a grant or stops requesting.
    always_comb begin
        state_d = (state_q == ST_LOCK0) ? ((req_i[0] && lock_i[0]) ? ST_LOCK0 : ST_OPEN) :
                  (state_q == ST_LOCK1) ? ((req_i[1] && lock_i[1]) ? ST_LOCK1 : ST_OPEN) :
                  (gnt_o[0] && lock_i[0]) ? ST_LOCK0 :
                  (gnt_o[1] && lock_i[1]) ? ST_LOCK1 : ST_OPEN;
        rr_last_d = (|gnt_o) ? gnt_o[1] : rr_last_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_OPEN;
            rr_last_q <= PORT1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end
endmodule

// File: rtl/nios2_small_onchip_mem_arbiter.sv
// nios2_small_onchip_mem_arbiter: two requesters sharing one on-chip memory with 1-cycle read latency
module nios2_small_onchip_mem_arbiter
    import nios2_small_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic                m0_lock,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic                m1_lock,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata
);
    logic [1:0]          req, gnt;
    logic                any, g_wr, in_rng;
    logic [ADDR_W-1:0]   g_addr, addr_q, addr_d;
    logic [DATA_W/8-1:0] g_be, be_q, be_d;
    logic [DATA_W-1:0]   g_wd, wd_q, wd_d, rd_word;
    logic                pend_v_q, pend_v_d, pend_p_q, pend_p_d, pend_z_q, pend_z_d;

    assign req = {m1_read | m1_write, m0_read | m0_write};

    nios2_small_rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req),
        .lock_i ({m1_lock, m0_lock}),
        .gnt_o  (gnt)
    );

    always_comb begin
        any    = |gnt;
        g_addr = gnt[1] ? m1_address : m0_address;
        g_be   = gnt[1] ? m1_byteenable : m0_byteenable;
        g_wd   = gnt[1] ? m1_writedata : m0_writedata;
        g_wr   = gnt[1] ? m1_write : m0_write;
        in_rng = 32'(g_addr) < 32'(DEPTH);
        addr_d = any ? g_addr : addr_q;
        be_d   = any ? g_be : be_q;
        wd_d   = any ? g_wd : wd_q;
        pend_v_d = any && !g_wr;
        pend_p_d = gnt[1];
        pend_z_d = !in_rng;
    end

    // Accesses beyond DEPTH are accepted but never reach the memory.
    always_comb begin
        m0_waitrequest   = !gnt[0];
        m1_waitrequest   = !gnt[1];
        mem_chipselect   = any && in_rng;
        mem_write        = any && in_rng && g_wr;
        mem_address      = reset ? '0 : addr_d;
        mem_byteenable   = reset ? '0 : be_d;
        mem_writedata    = reset ? '0 : wd_d;
        mem_clken        = 1'b1;
        rd_word          = pend_z_q ? '0 : mem_readdata;
        m0_readdatavalid = !reset && pend_v_q && (pend_p_q == PORT0);
        m1_readdatavalid = !reset && pend_v_q && (pend_p_q == PORT1);
        m0_readdata      = m0_readdatavalid ? rd_word : '0;
        m1_readdata      = m1_readdatavalid ? rd_word : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            be_q     <= '0;
            wd_q     <= '0;
            pend_v_q <= 1'b0;
            pend_p_q <= PORT0;
            pend_z_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            be_q     <= be_d;
            wd_q     <= wd_d;
            pend_v_q <= pend_v_d;
            pend_p_q <= pend_p_d;
            pend_z_q <= pend_z_d;
        end
    end
endmodule
